// File: rtl/cska_mword_sequencer.sv
// ---------------------------------------------------------------------------
// cska_mword_sequencer
//
// Purpose:
//   Multi-word add sequencer wrapped around an external 16-bit carry-skip
//   adder. Operand word pairs arrive least significant first. Each pair is
//   passed straight through to the adder together with the chained carry.
//   The adder's 17-bit result is captured into a registered valid/ready
//   output stream. One 16-bit adder therefore performs a WORDS*16-bit add.
//   The last word also carries the final carry-out and the signed-overflow
//   flag of the full-width add.
//
// Parameters:
//   WORDS  number of 16-bit words per operation (>= 1)
//   CNT_W  width of the word counter
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   start, start_cin   begin an operation (honoured only in IDLE) and its carry-in
//   in_valid/in_ready  operand word-pair handshake; in_a, in_b are the words
//   add_a/add_b/add_c  combinational drive to the adder
//   add_s              adder result {carry_out, sum[15:0]}
//   out_valid/out_ready  sum word handshake
//   out_sum            sum word
//   out_last           marks word WORDS-1
//   out_cout, out_ovf  final carry-out and signed overflow (last word only)
//   busy               state is not IDLE
//   done               one-cycle pulse after the last word is handed off
// ---------------------------------------------------------------------------
module cska_mword_sequencer #(
    parameter int WORDS = 4,
    parameter int CNT_W = $clog2(WORDS) + 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        start_cin,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    output logic [15:0] add_a,
    output logic [15:0] add_b,
    output logic        add_c,
    input  logic [16:0] add_s,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_sum,
    output logic        out_last,
    output logic        out_cout,
    output logic        out_ovf,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORDS - 1);

    state_t            state_reg,     state_next;
    logic              carry_reg,     carry_next;
    logic [CNT_W-1:0]  word_cnt_reg,  word_cnt_next;
    logic              out_valid_reg, out_valid_next;
    logic [15:0]       out_sum_reg,   out_sum_next;
    logic              out_last_reg,  out_last_next;
    logic              out_cout_reg,  out_cout_next;
    logic              out_ovf_reg,   out_ovf_next;
    logic              done_reg,      done_next;

    logic in_fire;
    logic out_fire;
    logic out_fire_last;
    logic is_last_word;
    logic word_ovf;

    // A beat may only be taken when the output register is free or is being
    // emptied this same cycle, which keeps the output stable under a stall.
    assign in_ready      = (state_reg == ST_RUN) && (!out_valid_reg || out_ready);
    assign in_fire       = in_valid && in_ready;
    assign out_fire      = out_valid_reg && out_ready;
    assign out_fire_last = out_fire && out_last_reg;
    assign is_last_word  = (word_cnt_reg == LAST_CNT);

    // Carry into bit 15 is a15^b15^s15; overflow is that carry XOR carry-out.
    assign word_ovf = (in_a[15] ^ in_b[15] ^ add_s[15]) ^ add_s[16];

    assign add_a = in_a;
    assign add_b = in_b;
    assign add_c = carry_reg;

    assign out_valid = out_valid_reg;
    assign out_sum   = out_sum_reg;
    assign out_last  = out_last_reg;
    assign out_cout  = out_cout_reg;
    assign out_ovf   = out_ovf_reg;
    assign busy      = (state_reg != ST_IDLE);
    assign done      = done_reg;

    always_comb begin
        state_next     = state_reg;
        carry_next     = carry_reg;
        word_cnt_next  = word_cnt_reg;
        out_valid_next = out_valid_reg;
        out_sum_next   = out_sum_reg;
        out_last_next  = out_last_reg;
        out_cout_next  = out_cout_reg;
        out_ovf_next   = out_ovf_reg;
        done_next      = out_fire_last;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next    = ST_RUN;
                    carry_next    = start_cin;
                    word_cnt_next = '0;
                end
            end
            ST_RUN: begin
                if (in_fire && is_last_word) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (out_fire_last) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (out_fire) begin
            out_valid_next = 1'b0;
        end

        // An accept overrides the drain above: the new word replaces the
        // one being handed off and out_valid stays high.
        if (in_fire) begin
            out_sum_next   = add_s[15:0];
            carry_next     = add_s[16];
            out_valid_next = 1'b1;
            out_last_next  = is_last_word;
            out_cout_next  = is_last_word & add_s[16];
            out_ovf_next   = is_last_word & word_ovf;
            word_cnt_next  = word_cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            carry_reg     <= 1'b0;
            word_cnt_reg  <= '0;
            out_valid_reg <= 1'b0;
            out_sum_reg   <= '0;
            out_last_reg  <= 1'b0;
            out_cout_reg  <= 1'b0;
            out_ovf_reg   <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            carry_reg     <= carry_next;
            word_cnt_reg  <= word_cnt_next;
            out_valid_reg <= out_valid_next;
            out_sum_reg   <= out_sum_next;
            out_last_reg  <= out_last_next;
            out_cout_reg  <= out_cout_next;
            out_ovf_reg   <= out_ovf_next;
            done_reg      <= done_next;
        end
    end

endmodule

// File: tb/tb_cska_mword_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cska_mword_sequencer
//
// Drives a WORDS=4 and a WORDS=1 instance of cska_mword_sequencer, each
// closed around a behavioural 16-bit adder. Expected results come from a
// full-width arithmetic model: the operands are summed as one wide integer,
// and the words, carry-out and signed overflow are sliced from that sum.
// ---------------------------------------------------------------------------
module tb_cska_mword_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start;
    logic        start_cin;
    logic        in_valid;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        out_ready;
    logic        sel;   // 0: WORDS=4 instance observed, 1: WORDS=1 instance

    // WORDS=4 instance
    logic        r4_in_ready, r4_add_c, r4_out_valid, r4_out_last;
    logic        r4_out_cout, r4_out_ovf, r4_busy, r4_done;
    logic [15:0] r4_add_a, r4_add_b, r4_out_sum;
    logic [16:0] r4_add_s;

    // WORDS=1 instance
    logic        r1_in_ready, r1_add_c, r1_out_valid, r1_out_last;
    logic        r1_out_cout, r1_out_ovf, r1_busy, r1_done;
    logic [15:0] r1_add_a, r1_add_b, r1_out_sum;
    logic [16:0] r1_add_s;

    // Behavioural adders standing in for the carry-skip adder
    assign r4_add_s = 17'(r4_add_a) + 17'(r4_add_b) + 17'(r4_add_c);
    assign r1_add_s = 17'(r1_add_a) + 17'(r1_add_b) + 17'(r1_add_c);

    cska_mword_sequencer #(.WORDS(4)) u_seq4 (
        .clk(clk), .rst(rst), .start(start), .start_cin(start_cin),
        .in_valid(in_valid), .in_ready(r4_in_ready), .in_a(in_a), .in_b(in_b),
        .add_a(r4_add_a), .add_b(r4_add_b), .add_c(r4_add_c), .add_s(r4_add_s),
        .out_valid(r4_out_valid), .out_ready(out_ready), .out_sum(r4_out_sum),
        .out_last(r4_out_last), .out_cout(r4_out_cout), .out_ovf(r4_out_ovf),
        .busy(r4_busy), .done(r4_done)
    );

    cska_mword_sequencer #(.WORDS(1)) u_seq1 (
        .clk(clk), .rst(rst), .start(start), .start_cin(start_cin),
        .in_valid(in_valid), .in_ready(r1_in_ready), .in_a(in_a), .in_b(in_b),
        .add_a(r1_add_a), .add_b(r1_add_b), .add_c(r1_add_c), .add_s(r1_add_s),
        .out_valid(r1_out_valid), .out_ready(out_ready), .out_sum(r1_out_sum),
        .out_last(r1_out_last), .out_cout(r1_out_cout), .out_ovf(r1_out_ovf),
        .busy(r1_busy), .done(r1_done)
    );

    logic        in_ready, out_valid, out_last, out_cout, out_ovf, busy, done;
    logic [15:0] out_sum;
    assign in_ready  = sel ? r1_in_ready  : r4_in_ready;
    assign out_valid = sel ? r1_out_valid : r4_out_valid;
    assign out_sum   = sel ? r1_out_sum   : r4_out_sum;
    assign out_last  = sel ? r1_out_last  : r4_out_last;
    assign out_cout  = sel ? r1_out_cout  : r4_out_cout;
    assign out_ovf   = sel ? r1_out_ovf   : r4_out_ovf;
    assign busy      = sel ? r1_busy      : r4_busy;
    assign done      = sel ? r1_done      : r4_done;

    int total_cnt = 0;
    int pass_cnt  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Runs one complete operation starting at a falling edge.
    // mode 0: always ready; 1: random valid/ready plus random start pulses;
    // 2: out_ready held low 5 cycles after the first output;
    // 3: always ready with start asserted (opposite cin) throughout RUN.
    task automatic run_op(input logic [63:0] a, input logic [63:0] b,
                          input logic cin, input int mode, input string name);
        int          n;
        int          msb;
        int          in_idx;
        int          out_idx;
        int          cyc;
        int          stall_left;
        logic        seen_out;
        logic [63:0] am;
        logic [63:0] bm;
        logic [64:0] sum_full;
        logic [15:0] exp_w [4];
        logic        exp_cout;
        logic        exp_ovf;
        logic        prev_stall;
        logic [15:0] held_sum;
        logic        held_last;
        logic        held_cout;
        logic        held_ovf;
        logic        is_last;

        n   = sel ? 1 : 4;
        msb = 16 * n - 1;
        am  = (n == 1) ? {48'h0, a[15:0]} : a;
        bm  = (n == 1) ? {48'h0, b[15:0]} : b;
        sum_full = {1'b0, am} + {1'b0, bm} + 65'(cin);
        for (int i = 0; i < 4; i++) exp_w[i] = sum_full[16*i +: 16];
        exp_cout = sum_full[16*n];
        exp_ovf  = (am[msb] == bm[msb]) && (sum_full[msb] != am[msb]);

        // Start cycle: a valid beat is offered but must not be taken.
        start     = 1'b1;
        start_cin = cin;
        in_valid  = 1'b1;
        in_a      = a[15:0];
        in_b      = b[15:0];
        out_ready = 1'b1;
        #1 check({name, ":start_in_ready"}, 64'(in_ready), 64'd0);
        @(negedge clk);
        start = 1'b0;
        #1 check({name, ":busy_after_start"}, 64'(busy), 64'd1);

        in_idx = 0; out_idx = 0; cyc = 0; stall_left = 0;
        seen_out = 1'b0; prev_stall = 1'b0;
        held_sum = '0; held_last = 1'b0; held_cout = 1'b0; held_ovf = 1'b0;

        while (out_idx < n && cyc < 300) begin
            if (mode == 1) begin
                start     = 1'($urandom_range(0, 1));
                start_cin = 1'($urandom_range(0, 1));
            end else if (mode == 3) begin
                start     = 1'b1;
                start_cin = ~cin;
            end else begin
                start = 1'b0;
            end

            if (in_idx < n) begin
                in_valid = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
                in_a     = a[16*in_idx +: 16];
                in_b     = b[16*in_idx +: 16];
            end else begin
                in_valid = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
                in_a     = 16'($urandom);
                in_b     = 16'($urandom);
            end

            if (mode == 1) begin
                out_ready = 1'($urandom_range(0, 1));
            end else if (mode == 2) begin
                if (out_valid && !seen_out) begin
                    seen_out   = 1'b1;
                    stall_left = 5;
                end
                out_ready = (stall_left > 0) ? 1'b0 : 1'b1;
                if (stall_left > 0) stall_left--;
            end else begin
                out_ready = 1'b1;
            end

            #1;
            if (prev_stall) begin
                check({name, ":hold_valid"}, 64'(out_valid), 64'd1);
                check({name, ":hold_sum"},   64'(out_sum),   64'(held_sum));
                check({name, ":hold_last"},  64'(out_last),  64'(held_last));
                check({name, ":hold_cout"},  64'(out_cout),  64'(held_cout));
                check({name, ":hold_ovf"},   64'(out_ovf),   64'(held_ovf));
            end
            if (out_valid && !out_ready)
                check({name, ":stall_in_ready"}, 64'(in_ready), 64'd0);
            if (in_idx >= n)
                check({name, ":drain_in_ready"}, 64'(in_ready), 64'd0);

            if (out_valid && out_ready) begin
                is_last = (out_idx == n - 1);
                $display("%s: word %0d sum=%h last=%b cout=%b ovf=%b", name, out_idx,
                         out_sum, out_last, out_cout, out_ovf);
                check({name, ":sum"},  64'(out_sum),  64'(exp_w[out_idx]));
                check({name, ":last"}, 64'(out_last), 64'(is_last));
                check({name, ":cout"}, 64'(out_cout), 64'(is_last ? exp_cout : 1'b0));
                check({name, ":ovf"},  64'(out_ovf),  64'(is_last ? exp_ovf : 1'b0));
                out_idx++;
            end

            prev_stall = out_valid && !out_ready;
            held_sum   = out_sum;
            held_last  = out_last;
            held_cout  = out_cout;
            held_ovf   = out_ovf;
            if (in_valid && in_ready) in_idx++;
            cyc++;
            @(negedge clk);
        end

        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        if (out_idx < n) begin
            check({name, ":timeout_words"}, 64'(out_idx), 64'(n));
        end else begin
            #1;
            check({name, ":done_pulse"}, 64'(done),      64'd1);
            check({name, ":idle_busy"},  64'(busy),      64'd0);
            check({name, ":idle_valid"}, 64'(out_valid), 64'd0);
            @(negedge clk);
            #1 check({name, ":done_clear"}, 64'(done), 64'd0);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, ":out_valid"}, 64'(out_valid), 64'd0);
        check({name, ":out_sum"},   64'(out_sum),   64'd0);
        check({name, ":out_last"},  64'(out_last),  64'd0);
        check({name, ":out_cout"},  64'(out_cout),  64'd0);
        check({name, ":out_ovf"},   64'(out_ovf),   64'd0);
        check({name, ":busy"},      64'(busy),      64'd0);
        check({name, ":done"},      64'(done),      64'd0);
        check({name, ":in_ready"},  64'(in_ready),  64'd0);
    endtask

    initial begin
        logic [63:0] ra;
        logic [63:0] rb;
        int          accepted;
        int          cyc;

        sel = 1'b0; rst = 1'b1; start = 1'b0; start_cin = 1'b0;
        in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1 check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        #1 check_reset_outputs("post_reset_idle");

        // Carry ripple, all-ones with carry-in, signed overflow
        run_op(64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_0001, 1'b0, 0, "ripple");
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 0, "ones_cin");
        run_op(64'h7FFF_0000_0000_0000, 64'h0001_0000_0000_0000, 1'b0, 0, "signed_ovf");

        // Backpressure with carries running through every word
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, 2, "backpressure");

        // start held high through RUN must not disturb the operation
        run_op(64'h8001_00FF_FFFF_FFFF, 64'h7FFF_FF00_0000_0001, 1'b0, 3, "start_in_run");

        // Reset in the middle of an operation
        start = 1'b1; start_cin = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; in_a = 16'hFFFF; in_b = 16'h4321;
        accepted = 0; cyc = 0;
        while (accepted < 2 && cyc < 20) begin
            #1;
            if (in_valid && in_ready) accepted++;
            cyc++;
            @(negedge clk);
        end
        check("midreset:beats_accepted", 64'(accepted), 64'd2);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        #1 check_reset_outputs("midreset");
        rst = 1'b0;
        @(negedge clk);
        run_op(64'h0000_0000_0000_0001, 64'h0000_0000_0000_0001, 1'b1, 0, "after_reset");

        // Random operations with random handshakes and stray start pulses
        for (int k = 0; k < 25; k++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (k % 5 == 0) rb = ~ra;
            run_op(ra, rb, 1'($urandom_range(0, 1)), 1, "rand4");
        end

        // Single-word instance
        rst = 1'b1;
        repeat (2) @(negedge clk);
        sel = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        #1 check_reset_outputs("w1_reset");
        run_op(64'h8000, 64'h8000, 1'b0, 0, "w1_8000");
        for (int k = 0; k < 10; k++) begin
            ra = {48'h0, 16'($urandom)};
            rb = {48'h0, 16'($urandom)};
            run_op(ra, rb, 1'($urandom_range(0, 1)), 1, "rand1");
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/cska_mword_sequencer.md
Name: cska_mword_sequencer

Overview:
- Multi-word add sequencer that sits directly around the 16-bit carry-skip adder.
- Accepts a stream of 16-bit operand word pairs, least significant first, and drives the adder's a/b/c inputs.
- Consumes the adder's 17-bit sum and chains the carry across WORDS beats, so one 16-bit adder performs a WORDS×16-bit addition.
- Emits sum words on a registered valid/ready stream, with the final carry-out and a signed-overflow flag on the last word.

Parameters:
- WORDS, 4, number of 16-bit words per operation (≥1); WORDS=4 gives a 64-bit add.
- CNT_W, $clog2(WORDS)+1, width of the word counter.

Ports:
- clk  input  1  Clock. All state updates on the rising edge.
- rst  input  1  Reset. Synchronous, active-high.
- start  input  1  Single-cycle request to begin an operation; only honoured in IDLE.
- start_cin  input  1  Carry-in for word 0, sampled together with start.
- in_valid  input  1  Operand word pair valid.
- in_ready  output  1  Sequencer accepts the pair this cycle.
- in_a  input  16  Operand A word.
- in_b  input  16  Operand B word.
- add_a  output  16  To adder a: combinational copy of in_a.
- add_b  output  16  To adder b: combinational copy of in_b.
- add_c  output  1  To adder c: copy of carry_q.
- add_s  input  17  From adder s: {carry_out, sum[15:0]}.
- out_valid  output  1  Sum word valid.
- out_ready  input  1  Downstream accepts the sum word.
- out_sum  output  16  Registered sum word.
- out_last  output  1  Marks word WORDS-1.
- out_cout  output  1  Final carry-out; meaningful only when out_last=1, otherwise 0.
- out_ovf  output  1  Signed overflow of the full-width add; meaningful only when out_last=1, otherwise 0.
- busy  output  1  High whenever the state is not IDLE.
- done  output  1  One-cycle pulse when the operation completes.

Behaviour:
- Reset values (rst=1 at a clock edge): state=IDLE, carry_q=0, word_cnt=0, out_valid=0, out_sum=0, out_last=0, out_cout=0, out_ovf=0, done=0.
  - Reset mid-operation aborts it; any pending output word is discarded.
- States:
  - IDLE → RUN when start=1: carry_q←start_cin, word_cnt←0.
  - RUN → DRAIN when the beat with word_cnt==WORDS-1 is accepted.
  - DRAIN → IDLE on the handshake of the last output word (out_valid & out_ready & out_last). done=1 in the following cycle only.
  - start is ignored in RUN and DRAIN.
- in_ready = (state==RUN) & (!out_valid | out_ready).
  - in_ready is 0 in IDLE and DRAIN, including the cycle in which start is sampled, so no beat is accepted that cycle.
- Accepted beat (in_valid & in_ready):
  - out_sum←add_s[15:0], carry_q←add_s[16], out_valid←1, out_last←(word_cnt==WORDS-1), word_cnt←word_cnt+1.
  - On the last beat also: out_cout←add_s[16] and out_ovf←(in_a[15]^in_b[15]^add_s[15])^add_s[16].
  - On non-last beats out_cout←0 and out_ovf←0.
- Output handshake (out_valid & out_ready) with no beat accepted in the same cycle: out_valid←0.
  - With a simultaneous accept, out_valid stays 1 and the new word replaces the old one.
- Latency and throughput: 1 cycle from accepted beat to out_valid; 1 word/cycle when out_ready is held high.
- Stall: while out_valid=1 and out_ready=0, all out_* outputs are held stable and in_ready=0. No word is lost or duplicated.
- Adder path: add_a/add_b/add_c are purely combinational; add_s is consumed in the same cycle. No arithmetic is performed inside this block other than the overflow XOR.
- WORDS=1: the first beat is also the last beat, so RUN→DRAIN after a single accept.

Test Plan:
- Carry ripple across words: WORDS=4, start_cin=0, beats (FFFF,0001),(0000,0000)×3 → out_sum 0000,0001,0000,0000; out_last only on beat 4; out_cout=0, out_ovf=0; done pulses 1 cycle after the last handshake.
- All ones with carry-in: start_cin=1, beats (FFFF,FFFF)×4 → every out_sum=FFFF, out_cout=1, out_ovf=0.
- Signed overflow: start_cin=0, beats (0000,0000)×3 then (7FFF,0001) → last out_sum=8000, out_cout=0, out_ovf=1.
- Backpressure: out_ready=0 for 5 cycles after the first output → in_ready=0 and out_sum stable throughout. After release, the remaining words arrive in order with correct carries.
- Reset mid-operation: rst=1 after 2 accepted beats → all outputs 0 and busy=0. A new start with start_cin=1 and beats (0001,0001),(0,0)×3 → first out_sum=0003, with no stale carry from the aborted operation.
- Control edge cases:
  - start pulsed during RUN is ignored; word_cnt and carry_q are unchanged.
  - WORDS=1 instance with (8000,8000), start_cin=0 → out_sum=0000, out_last=1, out_cout=1, out_ovf=1.
